// File: rtl/imm_pkg.sv
// Shared constants for the immediate extender: format codes and the
// bit positions of each immediate field inside the 26-bit instruction slice.
package imm_pkg;

    localparam logic [2:0] FMT_I  = 3'b000;
    localparam logic [2:0] FMT_D  = 3'b001;
    localparam logic [2:0] FMT_B  = 3'b010;
    localparam logic [2:0] FMT_CB = 3'b011;
    localparam logic [2:0] FMT_IW = 3'b100;

    localparam int IMM_W  = 26;
    localparam int I_LSB  = 10;
    localparam int I_MSB  = 21;
    localparam int I_SH   = 22;
    localparam int D_LSB  = 12;
    localparam int D_MSB  = 20;
    localparam int CB_LSB = 5;
    localparam int CB_MSB = 23;
    localparam int IW_LSB = 5;
    localparam int IW_MSB = 20;
    localparam int HW_LSB = 21;
    localparam int HW_MSB = 22;

    localparam int CNT_W  = 8;

endpackage

// File: rtl/imm_extend_pipe_if.sv
// Request/result handshake bundle between decode, the extender and execute.
interface imm_extend_pipe_if #(
    parameter int DATA_W = 64
);
    logic              in_valid;
    logic              in_ready;
    logic [25:0]       Imm26;
    logic [2:0]        Ctrl;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] BusImm;
    logic              err;
    logic [7:0]        count;

    modport slave (
        input  in_valid, Imm26, Ctrl, out_ready,
        output in_ready, out_valid, BusImm, err, count
    );

    modport master (
        output in_valid, Imm26, Ctrl, out_ready,
        input  in_ready, out_valid, BusImm, err, count
    );
endinterface

// File: rtl/imm_extend_core.sv
// Combinational immediate extraction and extension for all instruction formats.
// Illegal format codes and 32-bit-incompatible IW shifts yield zero with err set.
module imm_extend_core
    import imm_pkg::*;
#(
    parameter int DATA_W   = 64,
    parameter int BR_SHIFT = 0
) (
    input  logic [IMM_W-1:0]  imm26_i,
    input  logic [2:0]        ctrl_i,
    output logic [DATA_W-1:0] bus_imm_o,
    output logic              err_o
);
    localparam int I_W  = I_MSB - I_LSB + 1;
    localparam int D_W  = D_MSB - D_LSB + 1;
    localparam int CB_W = CB_MSB - CB_LSB + 1;
    localparam int IW_W = IW_MSB - IW_LSB + 1;

    logic [I_W-1:0]  i_fld;
    logic [D_W-1:0]  d_fld;
    logic [CB_W-1:0] cb_fld;
    logic [IW_W-1:0] iw_fld;
    logic [1:0]      hw;

    assign i_fld  = imm26_i[I_MSB:I_LSB];
    assign d_fld  = imm26_i[D_MSB:D_LSB];
    assign cb_fld = imm26_i[CB_MSB:CB_LSB];
    assign iw_fld = imm26_i[IW_MSB:IW_LSB];
    assign hw     = imm26_i[HW_MSB:HW_LSB];

    always_comb begin
        bus_imm_o = '0;
        err_o     = 1'b0;
        case (ctrl_i)
            FMT_I: begin
                bus_imm_o = {{(DATA_W-I_W){1'b0}}, i_fld};
                if (imm26_i[I_SH]) bus_imm_o = bus_imm_o << 12;
            end
            FMT_D: bus_imm_o = {{(DATA_W-D_W){d_fld[D_W-1]}}, d_fld};
            FMT_B: begin
                bus_imm_o = {{(DATA_W-IMM_W){imm26_i[IMM_W-1]}}, imm26_i};
                if (BR_SHIFT != 0) bus_imm_o = bus_imm_o << 2;
            end
            FMT_CB: begin
                bus_imm_o = {{(DATA_W-CB_W){cb_fld[CB_W-1]}}, cb_fld};
                if (BR_SHIFT != 0) bus_imm_o = bus_imm_o << 2;
            end
            FMT_IW: begin
                // A 32-bit datapath cannot hold halfwords 2 and 3
                if (DATA_W == 32 && hw[1]) err_o = 1'b1;
                else bus_imm_o = {{(DATA_W-IW_W){1'b0}}, iw_fld} << {hw, 4'b0000};
            end
            default: err_o = 1'b1;
        endcase
    end
endmodule

// File: rtl/imm_extend_pipe.sv
// Registered immediate extender: one request stage feeding a small result FIFO.
// A FIFO slot is reserved at accept time so in_ready accounts for the in-flight request.
module imm_extend_pipe
    import imm_pkg::*;
#(
    parameter int DATA_W   = 64,
    parameter int DEPTH    = 2,
    parameter int BR_SHIFT = 0
) (
    input logic         CLK,
    input logic         Reset,
    imm_extend_pipe_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    typedef logic [AW:0] ptr_t;
    localparam ptr_t PTR_ONE = ptr_t'(1);

    // wr: slots reserved by accepts; cm: slots written with results; rd: slots popped
    ptr_t wr_ptr_q, wr_ptr_d;
    ptr_t cm_ptr_q, cm_ptr_d;
    ptr_t rd_ptr_q, rd_ptr_d;

    logic              pend_q;
    logic [IMM_W-1:0]  pend_imm_q;
    logic [2:0]        pend_ctrl_q;
    logic [DATA_W:0]   mem_q [DEPTH];
    logic [DATA_W:0]   hold_q, hold_d;
    logic [CNT_W-1:0]  count_q, count_d;

    logic              full, empty, push, pop;
    logic [DATA_W-1:0] core_imm;
    logic              core_err;
    logic [DATA_W:0]   head;

    imm_extend_core #(
        .DATA_W  (DATA_W),
        .BR_SHIFT(BR_SHIFT)
    ) u_core (
        .imm26_i  (pend_imm_q),
        .ctrl_i   (pend_ctrl_q),
        .bus_imm_o(core_imm),
        .err_o    (core_err)
    );

    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign empty = (cm_ptr_q == rd_ptr_q);
    assign push  = bus.in_valid && !full;
    assign pop   = !empty && bus.out_ready;
    assign head  = mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        cm_ptr_d = cm_ptr_q;
        rd_ptr_d = rd_ptr_q;
        hold_d   = hold_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
            count_d  = count_q + 8'd1;
        end
        if (pend_q) cm_ptr_d = cm_ptr_q + PTR_ONE;
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
            hold_d   = head;
        end
    end

    always_ff @(posedge CLK) begin
        if (Reset) begin
            wr_ptr_q <= '0;
            cm_ptr_q <= '0;
            rd_ptr_q <= '0;
            pend_q   <= 1'b0;
            hold_q   <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            cm_ptr_q <= cm_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            pend_q   <= push;
            hold_q   <= hold_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge CLK) begin
        if (push) begin
            pend_imm_q  <= bus.Imm26;
            pend_ctrl_q <= bus.Ctrl;
        end
        if (pend_q) mem_q[cm_ptr_q[AW-1:0]] <= {core_err, core_imm};
    end

    // When empty the outputs keep showing the most recently popped result
    assign bus.in_ready  = !full;
    assign bus.out_valid = !empty;
    assign bus.BusImm    = empty ? hold_q[DATA_W-1:0] : head[DATA_W-1:0];
    assign bus.err       = empty ? hold_q[DATA_W]     : head[DATA_W];
    assign bus.count     = count_q;
endmodule
